// File: rtl/folded_threshold_gate.sv
// Folded threshold/majority gate: consumes W bits per cycle of an N-bit vector
// and reports whether its popcount reaches a per-transaction threshold.
module folded_threshold_gate #(
  parameter int N          = 41,
  parameter int W          = 8,
  parameter int EARLY_EXIT = 0,
  parameter int CW         = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_vec,
  input  logic          in_mode,
  input  logic [CW-1:0] in_thr,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          y,
  output logic [CW-1:0] count
);

  localparam int NCH = (N + W - 1) / W;
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int PW  = NCH * W;
  localparam logic [CW-1:0] MAJ = CW'((N + 1) / 2);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state;
  logic [PW-1:0] vec;
  logic [CW-1:0] thr;
  logic [CW-1:0] acc;
  logic [IW-1:0] idx;

  logic [W-1:0]  chunk;
  logic [CW-1:0] pc;
  logic [CW-1:0] acc_nx;
  logic [CW:0]   slack;
  logic [CW-1:0] thr_in;
  logic          last;
  logic          hit;
  logic          miss;
  logic          decide;

  always_comb begin
    chunk = vec[int'(idx) * W +: W];
    pc = '0;
    for (int i = 0; i < W; i++) begin
      pc = pc + CW'(chunk[i]);
    end
    acc_nx = acc + pc;
    // Slack counts the current chunk as still open: conservative by one chunk.
    slack  = {1'b0, acc_nx} + (CW+1)'(N - int'(idx) * W);
    last   = (int'(idx) == NCH - 1);
    hit    = (acc_nx >= thr);
    miss   = (slack < {1'b0, thr});
    decide = last || ((EARLY_EXIT != 0) && (hit || miss));
    thr_in = in_mode ? in_thr : MAJ;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      y         <= 1'b0;
      count     <= '0;
      vec       <= '0;
      thr       <= '0;
      acc       <= '0;
      idx       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            vec      <= PW'(in_vec);
            thr      <= thr_in;
            acc      <= '0;
            idx      <= '0;
            in_ready <= 1'b0;
            if (thr_in == '0) begin
              y     <= 1'b1;
              count <= '0;
              state <= DONE;
            end else if (int'(thr_in) > N) begin
              y     <= 1'b0;
              count <= '0;
              state <= DONE;
            end else begin
              state <= ACCUM;
            end
          end
        end
        ACCUM: begin
          acc <= acc_nx;
          if (decide) begin
            y         <= hit;
            count     <= acc_nx;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          // Degenerate thresholds arrive here with out_valid still low.
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_folded_threshold_gate.sv
// Directed and random checks of folded_threshold_gate across four
// configurations driven in lockstep from shared inputs.
module tb_folded_threshold_gate;

  localparam int N  = 41;
  localparam int CW = 6;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic [N-1:0]  in_vec;
  logic          in_mode;
  logic [CW-1:0] in_thr;
  logic          out_ready;

  logic          ir [4];
  logic          ov [4];
  logic          yo [4];
  logic [CW-1:0] co [4];

  int wid [4] = '{8, 8, 1, 41};
  bit ee  [4] = '{0, 1, 0, 0};

  int glat [4];
  int gy   [4];
  int gc   [4];

  int n_tests = 0;
  int n_fail  = 0;

  folded_threshold_gate #(.N(N), .W(8), .EARLY_EXIT(0)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]),
    .in_vec(in_vec), .in_mode(in_mode), .in_thr(in_thr),
    .out_valid(ov[0]), .out_ready(out_ready), .y(yo[0]), .count(co[0])
  );

  folded_threshold_gate #(.N(N), .W(8), .EARLY_EXIT(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]),
    .in_vec(in_vec), .in_mode(in_mode), .in_thr(in_thr),
    .out_valid(ov[1]), .out_ready(out_ready), .y(yo[1]), .count(co[1])
  );

  folded_threshold_gate #(.N(N), .W(1), .EARLY_EXIT(0)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[2]),
    .in_vec(in_vec), .in_mode(in_mode), .in_thr(in_thr),
    .out_valid(ov[2]), .out_ready(out_ready), .y(yo[2]), .count(co[2])
  );

  folded_threshold_gate #(.N(N), .W(41), .EARLY_EXIT(0)) u3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[3]),
    .in_vec(in_vec), .in_mode(in_mode), .in_thr(in_thr),
    .out_valid(ov[3]), .out_ready(out_ready), .y(yo[3]), .count(co[3])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: latency in edges after accept, result and count.
  function automatic void model(input logic [N-1:0] v, input int thr,
                                input int w, input bit e,
                                output int lat, output int yv,
                                output int cv);
    int acc;
    int nch;
    acc = 0;
    nch = (N + w - 1) / w;
    lat = 1;
    yv  = 0;
    cv  = 0;
    if (thr == 0) begin
      yv = 1;
      return;
    end
    if (thr > N) return;
    for (int k = 0; k < nch; k++) begin
      for (int b = k * w; b < k * w + w; b++) begin
        if (b < N) acc += int'(v[b]);
      end
      if (k == nch - 1 ||
          (e && (acc >= thr || acc + N - k * w < thr))) begin
        lat = k + 1;
        yv  = (acc >= thr) ? 1 : 0;
        cv  = acc;
        return;
      end
    end
  endfunction

  task automatic launch(input logic [N-1:0] v, input logic m,
                        input logic [CW-1:0] t);
    @(negedge clk);
    for (int i = 0; i < 4; i++) check($sformatf("u%0d in_ready_idle", i), ir[i], 1);
    in_valid = 1'b1;
    in_vec   = v;
    in_mode  = m;
    in_thr   = t;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_vec   = ~v;
    in_mode  = ~m;
    in_thr   = t ^ 6'h15;
    check("u0 in_ready_busy", ir[0], 0);
  endtask

  task automatic collect();
    bit all;
    for (int i = 0; i < 4; i++) begin
      glat[i] = 0;
      gy[i]   = -1;
      gc[i]   = -1;
    end
    for (int e = 1; e <= 60; e++) begin
      @(posedge clk);
      #1;
      all = 1;
      for (int i = 0; i < 4; i++) begin
        if (glat[i] == 0 && ov[i]) begin
          glat[i] = e;
          gy[i]   = int'(yo[i]);
          gc[i]   = int'(co[i]);
        end
        if (glat[i] == 0) all = 0;
      end
      if (all) break;
    end
  endtask

  task automatic score(input logic [N-1:0] v, input logic m,
                       input logic [CW-1:0] t);
    int thr, lat, yv, cv;
    thr = m ? int'(t) : (N + 1) / 2;
    for (int i = 0; i < 4; i++) begin
      model(v, thr, wid[i], ee[i], lat, yv, cv);
      check($sformatf("u%0d latency", i), glat[i], lat);
      check($sformatf("u%0d y", i), gy[i], yv);
      check($sformatf("u%0d count", i), gc[i], cv);
    end
  endtask

  task automatic drain();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("u%0d out_valid_drop", i), ov[i], 0);
      check($sformatf("u%0d in_ready_back", i), ir[i], 1);
    end
  endtask

  task automatic run(input logic [N-1:0] v, input logic m,
                     input logic [CW-1:0] t);
    launch(v, m, t);
    collect();
    score(v, m, t);
    drain();
  endtask

  initial begin
    logic [63:0] r;
    bit seen;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_vec    = '0;
    in_mode   = 1'b0;
    in_thr    = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("u%0d rst in_ready", i), ir[i], 1);
      check($sformatf("u%0d rst out_valid", i), ov[i], 0);
      check($sformatf("u%0d rst y", i), yo[i], 0);
      check($sformatf("u%0d rst count", i), co[i], 0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    run(41'h1F_FFFF, 1'b0, 6'd0);
    check("maj21 u0 lat", glat[0], 6);
    check("maj21 u0 y", gy[0], 1);
    check("maj21 u0 count", gc[0], 21);
    check("maj21 u1 lat", glat[1], 3);
    check("maj21 u2 lat", glat[2], 41);
    check("maj21 u3 lat", glat[3], 1);

    run(41'h0F_FFFF, 1'b0, 6'd0);
    check("maj20 u0 y", gy[0], 0);
    check("maj20 u0 count", gc[0], 20);

    run({N{1'b1}}, 1'b0, 6'd0);
    check("ones u1 lat", glat[1], 3);
    check("ones u1 count", gc[1], 24);
    check("ones u0 count", gc[0], 41);

    run('0, 1'b0, 6'd0);
    check("zeros u1 lat", glat[1], 4);
    check("zeros u1 y", gy[1], 0);
    check("zeros u0 y", gy[0], 0);

    run(41'h155_5555_5555, 1'b1, 6'd0);
    check("thr0 u0 lat", glat[0], 1);
    check("thr0 u0 y", gy[0], 1);
    check("thr0 u0 count", gc[0], 0);

    run({N{1'b1}}, 1'b1, 6'd42);
    check("thr42 u0 lat", glat[0], 1);
    check("thr42 u0 y", gy[0], 0);

    run(41'h100_0000_0107, 1'b1, 6'd5);
    check("thr5 u0 y", gy[0], 1);
    check("thr5 u0 count", gc[0], 5);

    for (int k = 0; k < 150; k++) begin
      r = {$urandom(), $urandom()};
      run(r[N-1:0], 1'b0, 6'd0);
    end
    for (int k = 0; k < 20; k++) begin
      r = {$urandom(), $urandom()};
      run(r[N-1:0], 1'b1, 6'($urandom_range(1, 41)));
    end

    // Backpressure: result must hold while the sink stalls.
    launch(41'h0FF_00FF_00FF, 1'b0, 6'd0);
    collect();
    score(41'h0FF_00FF_00FF, 1'b0, 6'd0);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      check("bp out_valid", ov[0], 1);
      check("bp y", yo[0], gy[0]);
      check("bp count", co[0], gc[0]);
      check("bp in_ready", ir[0], 0);
    end
    drain();
    run(41'h1F_FFFF, 1'b0, 6'd0);

    // Abort mid-accumulation with an asynchronous reset.
    launch({N{1'b1}}, 1'b0, 6'd0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort out_valid", ov[0], 0);
    check("abort in_ready", ir[0], 1);
    check("abort y", yo[0], 0);
    check("abort count", co[0], 0);
    check("abort u2 count", co[2], 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) if (ov[i]) seen = 1;
    end
    check("abort no stale out_valid", seen, 0);
    run(41'h0F_FFFF, 1'b0, 6'd0);
    check("post abort u0 count", gc[0], 20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
